// File: rtl/pci_bus_arbiter_if.sv
// Shared Req/Frame/Irdy/Gnt bundle between the central arbiter and the bus initiators.
// The master modport is the arbiter's view (it masters the grant lines); slave is the initiators' view.
interface pci_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] Req;
  logic                   Frame;
  logic                   Irdy;
  logic [NUM_MASTERS-1:0] Gnt;
  logic [2:0]             Owner;
  logic                   Bus_idle;
  logic                   Timeout_err;

  modport master (
    input  Req, Frame, Irdy,
    output Gnt, Owner, Bus_idle, Timeout_err
  );

  modport slave (
    output Req, Frame, Irdy,
    input  Gnt, Owner, Bus_idle, Timeout_err
  );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: grants one initiator, follows FRAME#/IRDY#, forces a one-cycle
// turnaround gap between owners and revokes grants left unused for IDLE_TIMEOUT clocks.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic               clk,
  input  logic               rst,
  pci_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANTED,
    S_BUSY,
    S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [2:0]             owner_q, owner_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic [NUM_MASTERS-1:0] req_act;
  logic [NUM_MASTERS-1:0] other_req;
  logic [7:0]             req_pad;
  logic [2:0]             win;
  logic                   win_found;
  logic                   own_req;
  logic                   bus_idle;
  logic [CNT_W-1:0]       cnt_inc;

  // Active-high request view, and the requests from everyone except the current owner.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
    assign req_act[gi]   = ~bus.Req[gi];
    assign other_req[gi] = req_act[gi] && (owner_q != 3'(gi));
  end

  assign req_pad  = 8'(req_act);
  assign own_req  = req_pad[owner_q];
  assign bus_idle = bus.Frame & bus.Irdy;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Walk from the highest offset down so the requester closest to ptr is the one kept.
  always_comb begin
    logic [3:0] sum;
    win       = ptr_q;
    win_found = 1'b0;
    sum       = 4'd0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + 4'(i);
      if (sum >= 4'(NUM_MASTERS)) begin
        sum = sum - 4'(NUM_MASTERS);
      end
      if (req_pad[sum[2:0]]) begin
        win       = sum[2:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = '1;
        if (win_found) begin
          gnt_d   = {NUM_MASTERS{1'b1}} ^ (NUM_MASTERS'(1) << win);
          owner_d = win;
          ptr_d   = (win == 3'(NUM_MASTERS - 1)) ? 3'd0 : win + 3'd1;
          cnt_d   = '0;
          state_d = S_GRANTED;
        end
      end

      // Frame takes priority over both withdrawal and timeout on the same edge.
      S_GRANTED: begin
        if (!bus.Frame) begin
          state_d = S_BUSY;
        end else if (!own_req) begin
          gnt_d   = '1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(IDLE_TIMEOUT)) begin
            gnt_d   = '1;
            err_d   = 1'b1;
            state_d = S_GAP;
          end
        end
      end

      // Once removed, the grant stays removed; the owner only finishes what it started.
      S_BUSY: begin
        if (bus_idle) begin
          gnt_d   = '1;
          state_d = S_GAP;
        end else if ((|other_req) || !own_req) begin
          gnt_d = '1;
        end
      end

      S_GAP: begin
        gnt_d   = '1;
        state_d = S_IDLE;
      end

      default: begin
        gnt_d   = '1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '1;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.Gnt         = gnt_q;
  assign bus.Owner       = owner_q;
  assign bus.Bus_idle    = bus_idle;
  assign bus.Timeout_err = err_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a session-level model of bus ownership.
module tb_pci_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pci_bus_arbiter_if #(.NUM_MASTERS(N)) bus_if ();

  pci_bus_arbiter #(
    .NUM_MASTERS (N),
    .IDLE_TIMEOUT(TO),
    .CNT_W       (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a "session" is the period one master owns the bus, from grant until it
  // withdraws, times out or the bus goes idle after its transaction.
  int m_session = -1;   // master owning the session, -1 if none
  int m_holder  = -1;   // master whose GNT# is currently low, -1 if none
  int m_owner   = 0;
  int m_ptr     = 0;
  int m_cool    = 0;    // edges of turnaround left before arbitration may run
  int m_idle    = 0;    // idle edges counted while granted but not started
  bit m_started = 1'b0;
  bit m_err     = 1'b0;

  task automatic end_session();
    m_session = -1;
    m_holder  = -1;
    m_cool    = 1;
  endtask

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_session = -1; m_holder = -1; m_owner = 0; m_ptr = 0;
      m_cool = 0; m_idle = 0; m_started = 1'b0; m_err = 1'b0;
    end else begin
      logic [N-1:0] rq;
      bit fr, ir, found;
      rq = bus_if.Req; fr = bus_if.Frame; ir = bus_if.Irdy;
      m_err = 1'b0;
      if (m_session < 0) begin
        if (m_cool > 0) begin
          m_cool--;
        end else begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && !rq[c]) begin
              found = 1'b1;
              m_session = c; m_holder = c; m_owner = c;
              m_ptr = (c + 1) % N; m_started = 1'b0; m_idle = 0;
            end
          end
        end
      end else if (!m_started) begin
        if (!fr) begin
          m_started = 1'b1;
        end else if (rq[m_session]) begin
          end_session();
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            end_session();
            m_err = 1'b1;
          end
        end
      end else begin
        if (fr && ir) begin
          end_session();
        end else if (rq[m_session] || ((~rq) & ~(N'(1) << m_session)) != '0) begin
          m_holder = -1;
        end
      end
    end
  end

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '1;
    if (m_holder >= 0) g[m_holder] = 1'b0;
    return g;
  endfunction

  // Compare process: outputs are stable between negedges, checked on every posedge.
  logic [N-1:0] prev_gnt = '1;
  always @(posedge clk) begin
    if (rst) begin
      cmp("gnt", int'(bus_if.Gnt), int'(exp_gnt()));
      cmp("owner", int'(bus_if.Owner), m_owner);
      cmp("timeout_err", int'(bus_if.Timeout_err), int'(m_err));
      cmp("bus_idle", int'(bus_if.Bus_idle), int'(bus_if.Frame & bus_if.Irdy));
      checks++;
      assert ($countones(~bus_if.Gnt | ~prev_gnt) <= 1)
      else begin
        failures++;
        $display("FAIL gnt_exclusive: actual=%b prev=%b required at most one low bit", bus_if.Gnt, prev_gnt);
      end
      prev_gnt = bus_if.Gnt;
    end else begin
      prev_gnt = '1;
    end
  end

  task automatic set_in(input logic [N-1:0] r, input logic f, input logic i);
    bus_if.Req   = r;
    bus_if.Frame = f;
    bus_if.Irdy  = i;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in('1, 1'b1, 1'b1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [N-1:0] rq;
    logic f, ir;
    set_in('1, 1'b1, 1'b1);
    rst = 1'b0;
    cyc(); cyc();
    cmp("rst_gnt", int'(bus_if.Gnt), 'hF);
    cmp("rst_owner", int'(bus_if.Owner), 0);
    cmp("rst_err", int'(bus_if.Timeout_err), 0);
    rst = 1'b1;

    // T1: single request, transaction, release
    set_in(4'b1011, 1'b1, 1'b1); cyc();
    cmp("t1_gnt", int'(bus_if.Gnt), 'hB);
    cmp("t1_owner", int'(bus_if.Owner), 2);
    set_in(4'b1011, 1'b0, 1'b0); cyc();
    cmp("t1_busy_gnt", int'(bus_if.Gnt), 'hB);
    set_in(4'b1011, 1'b1, 1'b1); cyc();
    cmp("t1_gap_gnt", int'(bus_if.Gnt), 'hF);
    set_in(4'b1111, 1'b1, 1'b1); cyc(); cyc();

    // T6: withdrawal while granted
    do_reset();
    set_in(4'b1011, 1'b1, 1'b1); cyc();
    cmp("t6_gnt", int'(bus_if.Gnt), 'hB);
    set_in(4'b1111, 1'b1, 1'b1); cyc();
    cmp("t6_release", int'(bus_if.Gnt), 'hF);
    cmp("t6_err", int'(bus_if.Timeout_err), 0);

    // T3: idle timeout, then next requester two edges later
    do_reset();
    set_in(4'b1100, 1'b1, 1'b1); cyc();
    cmp("t3_gnt0", int'(bus_if.Gnt), 'hE);
    repeat (15) cyc();
    cmp("t3_before_to", int'(bus_if.Gnt), 'hE);
    cmp("t3_no_err_yet", int'(bus_if.Timeout_err), 0);
    cyc();
    cmp("t3_revoked", int'(bus_if.Gnt), 'hF);
    cmp("t3_err_pulse", int'(bus_if.Timeout_err), 1);
    cyc();
    cmp("t3_err_cleared", int'(bus_if.Timeout_err), 0);
    cyc();
    cmp("t3_next_gnt", int'(bus_if.Gnt), 'hD);
    cmp("t3_next_owner", int'(bus_if.Owner), 1);

    // T5: asynchronous reset mid-transaction
    set_in(4'b1100, 1'b0, 1'b1); cyc();
    #1 rst = 1'b0;
    #1;
    cmp("t5_gnt_async", int'(bus_if.Gnt), 'hF);
    cmp("t5_owner_async", int'(bus_if.Owner), 0);
    set_in(4'b0000, 1'b1, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    cmp("t5_first_gnt", int'(bus_if.Gnt), 'hE);
    cmp("t5_first_owner", int'(bus_if.Owner), 0);

    // T4: preemption of a busy owner by another request
    do_reset();
    set_in(4'b1101, 1'b1, 1'b1); cyc();
    cmp("t4_gnt1", int'(bus_if.Gnt), 'hD);
    set_in(4'b1101, 1'b0, 1'b1); cyc();
    cmp("t4_busy", int'(bus_if.Gnt), 'hD);
    set_in(4'b0101, 1'b0, 1'b0); cyc();
    cmp("t4_preempt", int'(bus_if.Gnt), 'hF);
    set_in(4'b0101, 1'b1, 1'b0); cyc();
    cmp("t4_held", int'(bus_if.Gnt), 'hF);
    set_in(4'b0101, 1'b1, 1'b1); cyc();
    cmp("t4_gap", int'(bus_if.Gnt), 'hF);
    cyc();
    cmp("t4_idle", int'(bus_if.Gnt), 'hF);
    cyc();
    cmp("t4_gnt3", int'(bus_if.Gnt), 'h7);
    set_in(4'b1111, 1'b1, 1'b1); cyc(); cyc(); cyc();

    // T2: round-robin order with one-phase transactions
    do_reset();
    set_in(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (bus_if.Gnt == 4'hF && n < 10) begin
        cyc();
        n++;
      end
      cmp("t2_latency", n, (k == 0) ? 1 : 3);
      cmp("t2_owner", int'(bus_if.Owner), k % N);
      set_in(4'b0000, 1'b0, 1'b1); cyc();
      set_in(4'b0000, 1'b1, 1'b0); cyc();
      set_in(4'b0000, 1'b1, 1'b1);
    end

    // Random traffic against the model
    do_reset();
    rq = '1; f = 1'b1; ir = 1'b1;
    repeat (3000) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(0, 7) == 0) f = ~f;
      if ($urandom_range(0, 3) == 0) ir = 1'($urandom_range(0, 1));
      set_in(rq, f, ir);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
